// File: rtl/pwm_pkg.sv
// Shared definitions for the SPI command controller: opcodes, frame tags, FSM states.
// Latency: none, constants and a pure helper function only.
// Backpressure: not applicable.
package pwm_pkg;

  localparam int FRAME_W = 40;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_SET_DUTY  = 4'h1;
  localparam logic [3:0] OP_SET_EN    = 4'h2;
  localparam logic [3:0] OP_SET_PRESC = 4'h3;
  localparam logic [3:0] OP_RD_DUTY   = 4'h4;
  localparam logic [3:0] OP_RD_SENS   = 4'h5;
  localparam logic [3:0] OP_RD_STAT   = 4'h6;

  localparam logic [7:0]         TAG_DUTY      = 8'hD1;
  localparam logic [7:0]         TAG_STAT      = 8'h5A;
  localparam logic [FRAME_W-1:0] FRAME_TIMEOUT = 40'hEE_0000_0000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SENS_REQ  = 2'd1,
    SENS_WAIT = 2'd2
  } state_e;

  // Event counters stick at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/resp_frame_buf.sv
// Pending response register and hand-off into the SPI slave's parallel-load frame.
// Latency: a frame pending at cycle N reaches resp_frame_o at the first edge after N with frame_lock_i low.
// Backpressure: frame_lock_i freezes resp_frame_o; a newer load overwrites an undelivered frame.
module resp_frame_buf
  import pwm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_vld_i,
  input  logic [FRAME_W-1:0] load_dat_i,
  input  logic               frame_lock_i,
  output logic [FRAME_W-1:0] resp_frame_o
);

  logic [FRAME_W-1:0] pend_q, pend_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pend_vld_q, pend_vld_d;
  logic               xfer;

  // Hand the pending frame over only while the slave is deselected; a load in the
  // same cycle refills the slot, so the newest frame is never lost.
  always_comb begin
    xfer       = pend_vld_q & ~frame_lock_i;
    frame_d    = xfer ? pend_q : frame_q;
    pend_d     = load_vld_i ? load_dat_i : pend_q;
    pend_vld_d = load_vld_i | (pend_vld_q & ~xfer);
  end

  // Frame and pending registers; reset discards any undelivered frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      frame_q    <= frame_d;
    end
  end

  assign resp_frame_o = frame_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI command words into PWM config writes, sensor reads and response frames.
// Latency: writes visible 1 cycle after word_valid; read frames pending after 1 cycle.
// Backpressure: words arriving while a sensor read is in flight are dropped and counted.
module spi_cmd_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           word_data,
  input  logic                  word_valid,
  input  logic                  frame_lock,
  input  logic                  sens_ack,
  input  logic [FRAME_W-1:0]    sens_data,
  output logic                  sens_req,
  output logic [8*NUM_CH-1:0]   duty,
  output logic [NUM_CH-1:0]     en_mask,
  output logic [7:0]            prescale,
  output logic [FRAME_W-1:0]    resp_frame,
  output logic                  busy
);

  localparam int             TW         = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_e                    state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NUM_CH-1:0][7:0]    duty_q, duty_d;
  logic [NUM_CH-1:0]         en_q, en_d;
  logic [7:0]                presc_q, presc_d;
  logic [7:0]                err_q, err_d;
  logic [7:0]                drop_q, drop_d;
  logic                      to_q, to_d;
  logic                      bad_q, bad_d;

  logic [3:0]                op, ch;
  logic [7:0]                arg;
  logic                      ch_ok;
  logic [7:0]                duty_sel;
  logic                      bad_word;
  logic                      pend_ld;
  logic [FRAME_W-1:0]        pend_dat;

  assign op  = word_data[15:12];
  assign ch  = word_data[11:8];
  assign arg = word_data[7:0];

  // Decode, sensor handshake sequencing and all next-state values.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    duty_d   = duty_q;
    en_d     = en_q;
    presc_d  = presc_q;
    err_d    = err_q;
    drop_d   = drop_q;
    to_d     = to_q;
    bad_d    = bad_q;
    pend_ld  = 1'b0;
    pend_dat = '0;
    bad_word = 1'b0;
    ch_ok    = (32'(ch) < NUM_CH);
    duty_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 4'(k)) duty_sel = duty_q[k];
    end

    case (state_q)
      IDLE: begin
        if (word_valid) begin
          case (op)
            OP_NOP: ;
            OP_SET_DUTY: begin
              if (ch_ok) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  if (ch == 4'(k)) duty_d[k] = arg;
                end
              end else begin
                bad_word = 1'b1;
              end
            end
            OP_SET_EN:    en_d    = NUM_CH'(arg);
            OP_SET_PRESC: presc_d = arg;
            OP_RD_DUTY: begin
              if (ch_ok) begin
                pend_ld  = 1'b1;
                pend_dat = {TAG_DUTY, 4'h0, ch, 16'h0000, duty_sel};
              end else begin
                bad_word = 1'b1;
              end
            end
            OP_RD_SENS: state_d = SENS_REQ;
            OP_RD_STAT: begin
              // Flags are reported, then cleared; counters keep running.
              pend_ld  = 1'b1;
              pend_dat = {TAG_STAT, 8'(en_q), err_q, drop_q, 6'b0, to_q, bad_q};
              to_d     = 1'b0;
              bad_d    = 1'b0;
            end
            default: bad_word = 1'b1;
          endcase
        end
      end
      SENS_REQ: begin
        timer_d = '0;
        state_d = SENS_WAIT;
      end
      SENS_WAIT: begin
        timer_d = timer_q + TW'(1);
        // An acknowledge in the timeout cycle still counts as a good read.
        if (sens_ack) begin
          pend_ld  = 1'b1;
          pend_dat = sens_data;
          state_d  = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          pend_ld  = 1'b1;
          pend_dat = FRAME_TIMEOUT;
          to_d     = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bad_word) begin
      err_d = sat_inc8(err_q);
      bad_d = 1'b1;
    end
    if (word_valid && (state_q != IDLE)) drop_d = sat_inc8(drop_q);
  end

  // FSM state and sensor timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Configuration registers, error/drop counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q  <= '0;
      en_q    <= '0;
      presc_q <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      to_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      to_q    <= to_d;
      bad_q   <= bad_d;
    end
  end

  resp_frame_buf u_resp_frame_buf (
    .clk          (clk),
    .rst          (rst),
    .load_vld_i   (pend_ld),
    .load_dat_i   (pend_dat),
    .frame_lock_i (frame_lock),
    .resp_frame_o (resp_frame)
  );

  assign busy     = (state_q != IDLE);
  assign sens_req = busy;
  assign duty     = duty_q;
  assign en_mask  = en_q;
  assign prescale = presc_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized scoreboard bench for spi_cmd_ctrl against a transaction-level model.
// Latency: stimulus pushes expectations; monitors pop them as the DUT presents results.
// Backpressure: frame_lock phases exercise held and overwritten response frames.
module tb_spi_cmd_ctrl;

  localparam int NUM_CH = 4;
  localparam int TOUT   = 16;
  localparam int CFG_W  = 8*NUM_CH + NUM_CH + 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [15:0]         word_data;
  logic                word_valid;
  logic                frame_lock;
  logic                sens_ack;
  logic [39:0]         sens_data;
  logic                sens_req;
  logic [8*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]   en_mask;
  logic [7:0]          prescale;
  logic [39:0]         resp_frame;
  logic                busy;

  spi_cmd_ctrl #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_lock (frame_lock),
    .sens_ack   (sens_ack),
    .sens_data  (sens_data),
    .sens_req   (sens_req),
    .duty       (duty),
    .en_mask    (en_mask),
    .prescale   (prescale),
    .resp_frame (resp_frame),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard queues
  typedef struct packed {
    int               due;
    logic [CFG_W-1:0] v;
  } cfg_exp_t;

  logic [39:0] frame_q [$];
  cfg_exp_t    cfg_q   [$];
  int          sens_q  [$];
  int          cyc = 0;

  // Reference model state
  logic [7:0]        m_duty [NUM_CH];
  logic [NUM_CH-1:0] m_en;
  logic [7:0]        m_presc, m_err, m_drop;
  logic              m_to, m_bad;
  logic [39:0]       m_pend, m_last;
  logic              m_pend_vld;

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CFG_W-1:0] m_cfg();
    logic [CFG_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[8 + NUM_CH + 8*k +: 8] = m_duty[k];
    v[8 +: NUM_CH] = m_en;
    v[7:0]         = m_presc;
    return v;
  endfunction

  task automatic push_cfg();
    cfg_exp_t e;
    e.due = cyc + 1;
    e.v   = m_cfg();
    cfg_q.push_back(e);
  endtask

  // The slave sees a new frame only when the lock is open; identical frames are invisible.
  task automatic m_deliver();
    if (m_pend_vld && !frame_lock) begin
      if (m_pend != m_last) frame_q.push_back(m_pend);
      m_last     = m_pend;
      m_pend_vld = 1'b0;
    end
  endtask

  task automatic m_read(input logic [39:0] f);
    m_pend     = f;
    m_pend_vld = 1'b1;
    m_deliver();
  endtask

  task automatic m_error();
    m_err = sat(m_err);
    m_bad = 1'b1;
  endtask

  task automatic m_clear();
    for (int k = 0; k < NUM_CH; k++) m_duty[k] = 8'h00;
    m_en = '0; m_presc = '0; m_err = '0; m_drop = '0;
    m_to = 1'b0; m_bad = 1'b0; m_pend = '0; m_pend_vld = 1'b0;
  endtask

  task automatic m_reset();
    m_clear();
    if (m_last != 40'h0) frame_q.push_back(40'h0);
    m_last = 40'h0;
    push_cfg();
  endtask

  task automatic m_word(input logic [15:0] w);
    logic [3:0] op, ch;
    logic [7:0] arg;
    op = w[15:12]; ch = w[11:8]; arg = w[7:0];
    case (op)
      4'h0: ;
      4'h1: if (ch < NUM_CH) m_duty[ch[1:0]] = arg; else m_error();
      4'h2: m_en = arg[NUM_CH-1:0];
      4'h3: m_presc = arg;
      4'h4: if (ch < NUM_CH) m_read({8'hD1, 4'h0, ch, 16'h0000, m_duty[ch[1:0]]}); else m_error();
      4'h6: begin
        m_read({8'h5A, 8'(m_en), m_err, m_drop, 6'b0, m_to, m_bad});
        m_to  = 1'b0;
        m_bad = 1'b0;
      end
      default: m_error();
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Single word issued while the controller is idle (never RD_SENS).
  task automatic send_word(input logic [15:0] w);
    word_data  = w;
    word_valid = 1'b1;
    m_word(w);
    push_cfg();
    tick();
    word_valid = 1'b0;
  endtask

  // Sensor read: ack d cycles after sens_req rises (d > TOUT means no ack),
  // optional dropped word at drop_at, optional reset at rst_at.
  task automatic sens_txn(input int d, input logic [39:0] data, input int drop_at, input int rst_at);
    int i, end_i;
    bit done;
    end_i      = (d <= TOUT) ? d : TOUT;
    word_data  = {4'h5, 12'($urandom)};
    word_valid = 1'b1;
    push_cfg();
    tick();
    word_valid = 1'b0;
    chk("sens_req_rise", {63'd0, sens_req}, 64'd1);
    if (!sens_req) return;
    i = 0;
    done = 1'b0;
    while (!done) begin
      tick();
      i++;
      word_valid = 1'b0;
      sens_ack   = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        sens_q.push_back(i + 1);
        m_reset();
        tick();
        rst  = 1'b0;
        done = 1'b1;
      end else begin
        if (i == drop_at) begin
          word_data  = 16'($urandom);
          word_valid = 1'b1;
          m_drop     = sat(m_drop);
          push_cfg();
        end
        if (i == d) begin
          sens_ack  = 1'b1;
          sens_data = data;
        end
        if (i == end_i) begin
          sens_q.push_back(end_i + 1);
          if (d <= TOUT) begin
            m_read(data);
          end else begin
            m_read(40'hEE_0000_0000);
            m_to = 1'b1;
          end
          done = 1'b1;
        end
      end
    end
    tick();
    word_valid = 1'b0;
    sens_ack   = 1'b0;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [3:0] op, ch;
    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
    if (op == 4'h5) op = 4'h4;
    ch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NUM_CH-1));
    return {op, ch, 8'($urandom)};
  endfunction

  // Monitors
  logic        lock_at_edge = 1'b0;
  logic [39:0] seen = '0;
  bit          mon_en = 1'b0;
  int          slen = 0;
  int          blen = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    lock_at_edge <= frame_lock;
  end

  always @(negedge clk) begin
    cfg_exp_t e;
    int       exp_len;
    if (mon_en) begin
      if (resp_frame !== seen) begin
        chk("frame_lock_hold", {63'd0, lock_at_edge}, 64'd0);
        if (frame_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_frame_unexpected: got %h, expected no change from %h", resp_frame, seen);
        end else begin
          chk("resp_frame", {24'd0, resp_frame}, {24'd0, frame_q.pop_front()});
        end
        seen = resp_frame;
      end
      while (cfg_q.size() > 0 && cfg_q[0].due <= cyc) begin
        e = cfg_q.pop_front();
        chk("cfg_duty_en_presc", 64'({duty, en_mask, prescale}), 64'(e.v));
      end
      if (sens_req) begin
        slen++;
        if (busy) blen++;
      end else if (slen > 0) begin
        if (sens_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sens_req_unexpected: got %0d cycles high, expected none", slen);
        end else begin
          exp_len = sens_q.pop_front();
          chk("sens_req_len", 64'(slen), 64'(exp_len));
          chk("busy_len", 64'(blen), 64'(exp_len));
        end
        chk("busy_low", {63'd0, busy}, 64'd0);
        slen = 0;
        blen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, d, dr, n;
    rst = 1'b1; word_data = '0; word_valid = 1'b0; frame_lock = 1'b0;
    sens_ack = 1'b0; sens_data = '0;
    m_clear();
    m_last = '0;
    idle(3);
    rst = 1'b0;
    chk("reset_resp_frame", {24'd0, resp_frame}, 64'd0);
    chk("reset_sens_req", {63'd0, sens_req}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_cfg", 64'({duty, en_mask, prescale}), 64'd0);
    mon_en = 1'b1;
    tick();

    // Duty write, bad channel, status read
    send_word(16'h1280); idle(3);
    send_word(16'h1780); idle(3);
    send_word(16'h6000); idle(4);

    // Read duty while the frame is locked; newest pending frame delivered on unlock
    send_word(16'h1155); idle(2);
    frame_lock = 1'b1; tick();
    send_word(16'h4100); idle(6);
    frame_lock = 1'b0; m_deliver(); idle(4);

    // Sensor ack after 10 cycles with a dropped word, then status
    sens_txn(10, 40'h01F4_00FA_EF, 3, -1); idle(4);
    send_word(16'h6000); idle(4);

    // Sensor timeout, then status shows to_flag
    sens_txn(100, 40'($urandom), -1, -1); idle(4);
    send_word(16'h6000); idle(4);

    // Ack in the timeout cycle wins
    sens_txn(TOUT, {8'h3C, 32'($urandom)}, -1, -1); idle(4);
    send_word(16'h6000); idle(4);

    // Ack while idle is ignored
    sens_ack = 1'b1; sens_data = 40'($urandom); tick(); sens_ack = 1'b0; idle(3);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 19);
      if (r < 3) begin
        d  = $urandom_range(1, 20);
        dr = ((d > 1) && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, ((d <= TOUT) ? d : TOUT) - 1) : -1;
        sens_txn(d, {8'($urandom), 32'($urandom)}, dr, -1);
      end else if (r == 3) begin
        frame_lock = 1'b1; tick();
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          send_word(rnd_word()); idle(2);
        end
        frame_lock = 1'b0; m_deliver();
      end else if (r == 4) begin
        sens_ack = 1'b1; sens_data = 40'($urandom); tick(); sens_ack = 1'b0;
      end else begin
        send_word(rnd_word());
      end
      idle($urandom_range(3, 5));
    end

    // Reset mid-handshake, then a late ack that must be ignored
    send_word(16'h6000); idle(4);
    sens_txn(100, 40'($urandom), -1, 5); idle(3);
    sens_ack = 1'b1; sens_data = 40'($urandom); tick(); sens_ack = 1'b0; idle(4);
    send_word(16'h1280); idle(3);
    send_word(16'h6000); idle(10);

    chk("frame_q_drained", 64'(frame_q.size()), 64'd0);
    chk("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
    chk("sens_q_drained", 64'(sens_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
